// File: rtl/id_stage.sv
// Instruction-decode stage: register file, control decode, load-use detection, ID/EX register.
// Latency: IF/ID contents appear on IDEX_* one rising edge later; register reads bypass WB.
// Backpressure: ID_stall_o (combinational) holds IF/ID for one cycle on a load-use hazard.
module id_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] IFID_pc_i,
  input  logic [31:0] IFID_ir_i,
  input  logic        MEM_ctrl_pc_src_i,
  input  logic        WB_reg_write_i,
  input  logic [4:0]  WB_write_reg_i,
  input  logic [31:0] WB_write_data_i,
  output logic        ID_stall_o,
  output logic [31:0] IDEX_pc_o,
  output logic [31:0] IDEX_rs_data_o,
  output logic [31:0] IDEX_rt_data_o,
  output logic [31:0] IDEX_imm_o,
  output logic [4:0]  IDEX_rs_o,
  output logic [4:0]  IDEX_rt_o,
  output logic [4:0]  IDEX_rd_o,
  output logic        IDEX_reg_write_o,
  output logic        IDEX_mem_to_reg_o,
  output logic        IDEX_mem_read_o,
  output logic        IDEX_mem_write_o,
  output logic        IDEX_branch_o,
  output logic        IDEX_alu_src_o,
  output logic        IDEX_reg_dst_o,
  output logic [1:0]  IDEX_alu_op_o
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Instruction fields
  logic [5:0]  w_opcode;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [31:0] w_imm;

  assign w_opcode = IFID_ir_i[31:26];
  assign w_rs     = IFID_ir_i[25:21];
  assign w_rt     = IFID_ir_i[20:16];
  assign w_rd     = IFID_ir_i[15:11];
  assign w_imm    = {{16{IFID_ir_i[15]}}, IFID_ir_i[15:0]};

  // Register file storage; entry 0 is never written so it stays zero after reset
  logic [31:0] r_regs [0:31];

  // WB write port: rising-edge write, writes to r0 dropped, async clear on reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= 32'd0;
      end
    end else if (WB_reg_write_i && (WB_write_reg_i != 5'd0)) begin
      r_regs[WB_write_reg_i] <= WB_write_data_i;
    end
  end

  // Read ports with write-through so a WB write in this cycle is seen by this decode
  logic        w_wb_active;
  logic [31:0] w_rs_data;
  logic [31:0] w_rt_data;

  assign w_wb_active = WB_reg_write_i && (WB_write_reg_i != 5'd0);

  // Operand A read: r0 forced to zero, then bypass, then array
  always_comb begin
    w_rs_data = 32'd0;
    if (w_rs == 5'd0) begin
      w_rs_data = 32'd0;
    end else if (w_wb_active && (WB_write_reg_i == w_rs)) begin
      w_rs_data = WB_write_data_i;
    end else begin
      w_rs_data = r_regs[w_rs];
    end
  end

  // Operand B read: same structure as operand A
  always_comb begin
    w_rt_data = 32'd0;
    if (w_rt == 5'd0) begin
      w_rt_data = 32'd0;
    end else if (w_wb_active && (WB_write_reg_i == w_rt)) begin
      w_rt_data = WB_write_data_i;
    end else begin
      w_rt_data = r_regs[w_rt];
    end
  end

  // Control decode
  logic       w_reg_write;
  logic       w_mem_to_reg;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_branch;
  logic       w_alu_src;
  logic       w_reg_dst;
  logic [1:0] w_alu_op;
  logic       w_known_op;
  logic       w_uses_rt;

  // Opcode table; unknown opcodes decode to all-zero control and never count as known
  always_comb begin
    w_reg_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_branch     = 1'b0;
    w_alu_src    = 1'b0;
    w_reg_dst    = 1'b0;
    w_alu_op     = 2'b00;
    w_known_op   = 1'b0;
    w_uses_rt    = 1'b0;
    case (w_opcode)
      OP_RTYPE: begin
        w_reg_write = 1'b1;
        w_reg_dst   = 1'b1;
        w_alu_op    = 2'b10;
        w_known_op  = 1'b1;
        w_uses_rt   = 1'b1;
      end
      OP_LW: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_mem_read   = 1'b1;
        w_alu_src    = 1'b1;
        w_known_op   = 1'b1;
      end
      OP_SW: begin
        w_mem_write = 1'b1;
        w_alu_src   = 1'b1;
        w_known_op  = 1'b1;
        w_uses_rt   = 1'b1;
      end
      OP_BEQ: begin
        w_branch   = 1'b1;
        w_alu_op   = 2'b01;
        w_known_op = 1'b1;
        w_uses_rt  = 1'b1;
      end
      OP_ADDI: begin
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
        w_known_op  = 1'b1;
      end
      default: begin
        w_known_op = 1'b0;
      end
    endcase
  end

  // Load-use hazard: the load in EX targets a register this instruction reads
  logic w_rs_match;
  logic w_rt_match;
  logic w_hazard;

  assign w_rs_match = (IDEX_rt_o == w_rs);
  assign w_rt_match = (IDEX_rt_o == w_rt) && w_uses_rt;
  assign w_hazard   = IDEX_mem_read_o && (IDEX_rt_o != 5'd0) && w_known_op &&
                      (w_rs_match || w_rt_match);

  // A taken branch in MEM flushes instead, so fetch can redirect to the target
  assign ID_stall_o = w_hazard && !MEM_ctrl_pc_src_i;

  logic w_bubble;
  assign w_bubble = MEM_ctrl_pc_src_i || w_hazard;

  // ID/EX data fields: loaded every cycle, contents are irrelevant under a bubble
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      IDEX_pc_o      <= 32'd0;
      IDEX_rs_data_o <= 32'd0;
      IDEX_rt_data_o <= 32'd0;
      IDEX_imm_o     <= 32'd0;
      IDEX_rs_o      <= 5'd0;
      IDEX_rt_o      <= 5'd0;
      IDEX_rd_o      <= 5'd0;
    end else begin
      IDEX_pc_o      <= IFID_pc_i;
      IDEX_rs_data_o <= w_rs_data;
      IDEX_rt_data_o <= w_rt_data;
      IDEX_imm_o     <= w_imm;
      IDEX_rs_o      <= w_rs;
      IDEX_rt_o      <= w_rt;
      IDEX_rd_o      <= w_rd;
    end
  end

  // ID/EX control fields: flush or hazard inserts a bubble, otherwise take the decode
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      IDEX_reg_write_o  <= 1'b0;
      IDEX_mem_to_reg_o <= 1'b0;
      IDEX_mem_read_o   <= 1'b0;
      IDEX_mem_write_o  <= 1'b0;
      IDEX_branch_o     <= 1'b0;
      IDEX_alu_src_o    <= 1'b0;
      IDEX_reg_dst_o    <= 1'b0;
      IDEX_alu_op_o     <= 2'b00;
    end else if (w_bubble) begin
      IDEX_reg_write_o  <= 1'b0;
      IDEX_mem_to_reg_o <= 1'b0;
      IDEX_mem_read_o   <= 1'b0;
      IDEX_mem_write_o  <= 1'b0;
      IDEX_branch_o     <= 1'b0;
      IDEX_alu_src_o    <= 1'b0;
      IDEX_reg_dst_o    <= 1'b0;
      IDEX_alu_op_o     <= 2'b00;
    end else begin
      IDEX_reg_write_o  <= w_reg_write;
      IDEX_mem_to_reg_o <= w_mem_to_reg;
      IDEX_mem_read_o   <= w_mem_read;
      IDEX_mem_write_o  <= w_mem_write;
      IDEX_branch_o     <= w_branch;
      IDEX_alu_src_o    <= w_alu_src;
      IDEX_reg_dst_o    <= w_reg_dst;
      IDEX_alu_op_o     <= w_alu_op;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode, bypass, load-use stall, flush, r0, reset.
// Inputs change 1 ns after rising edges; outputs sampled between edges.
// Control bits compared as one vector {rw,m2r,mr,mw,br,as,rd,aluop[1:0]}.
module tb_id_stage;

  logic        clk;
  logic        rst;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_ir;
  logic        pc_src;
  logic        wb_we;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        stall;
  logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic        ex_rw, ex_m2r, ex_mr, ex_mw, ex_br, ex_as, ex_rdst;
  logic [1:0]  ex_aluop;

  int checks = 0;
  int failures = 0;

  id_stage dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .IFID_pc_i         (ifid_pc),
    .IFID_ir_i         (ifid_ir),
    .MEM_ctrl_pc_src_i (pc_src),
    .WB_reg_write_i    (wb_we),
    .WB_write_reg_i    (wb_reg),
    .WB_write_data_i   (wb_data),
    .ID_stall_o        (stall),
    .IDEX_pc_o         (ex_pc),
    .IDEX_rs_data_o    (ex_rs_data),
    .IDEX_rt_data_o    (ex_rt_data),
    .IDEX_imm_o        (ex_imm),
    .IDEX_rs_o         (ex_rs),
    .IDEX_rt_o         (ex_rt),
    .IDEX_rd_o         (ex_rd),
    .IDEX_reg_write_o  (ex_rw),
    .IDEX_mem_to_reg_o (ex_m2r),
    .IDEX_mem_read_o   (ex_mr),
    .IDEX_mem_write_o  (ex_mw),
    .IDEX_branch_o     (ex_br),
    .IDEX_alu_src_o    (ex_as),
    .IDEX_reg_dst_o    (ex_rdst),
    .IDEX_alu_op_o     (ex_aluop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [8:0] ctrl;
  assign ctrl = {ex_rw, ex_m2r, ex_mr, ex_mw, ex_br, ex_as, ex_rdst, ex_aluop};

  localparam logic [8:0] C_RTYPE  = 9'b1_0_0_0_0_0_1_10;
  localparam logic [8:0] C_LW     = 9'b1_1_1_0_0_1_0_00;
  localparam logic [8:0] C_SW     = 9'b0_0_0_1_0_1_0_00;
  localparam logic [8:0] C_BEQ    = 9'b0_0_0_0_1_0_0_01;
  localparam logic [8:0] C_ADDI   = 9'b1_0_0_0_0_1_0_00;
  localparam logic [8:0] C_BUBBLE = 9'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and move 1 ns past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
    wb_we = 1'b1; wb_reg = r; wb_data = d;
    tick();
    wb_we = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; ifid_pc = 32'd0; ifid_ir = 32'd0; pc_src = 1'b0;
    wb_we = 1'b0; wb_reg = 5'd0; wb_data = 32'd0;
    #12;
    chk("rst_ctrl", {23'd0, ctrl}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_pc", ex_pc, 32'd0);
    rst = 1'b0;

    // Preload registers (IF/ID holds a nop)
    wb_write(5'd1, 32'd7);
    wb_write(5'd2, 32'd9);
    wb_write(5'd5, 32'h1234);

    // R-type with same-cycle WB bypass on rt
    ifid_ir = 32'h00221820; ifid_pc = 32'h10;
    wb_we = 1'b1; wb_reg = 5'd2; wb_data = 32'h55;
    tick();
    wb_we = 1'b0;
    chk("add_rs_data", ex_rs_data, 32'd7);
    chk("add_rt_data", ex_rt_data, 32'h55);
    chk("add_rd", {27'd0, ex_rd}, 32'd3);
    chk("add_ctrl", {23'd0, ctrl}, {23'd0, C_RTYPE});
    chk("add_pc", ex_pc, 32'h10);

    // Load-use: lw r4,8(r1) then add r5,r4,r4
    ifid_ir = 32'h8C240008; ifid_pc = 32'h14;
    #1 chk("lw_nostall", {31'd0, stall}, 32'd0);
    tick();
    chk("lw_ctrl", {23'd0, ctrl}, {23'd0, C_LW});
    chk("lw_imm", ex_imm, 32'd8);
    chk("lw_rt", {27'd0, ex_rt}, 32'd4);
    ifid_ir = 32'h00842820; ifid_pc = 32'h18;
    #1 chk("lu_stall", {31'd0, stall}, 32'd1);
    tick();
    chk("lu_bubble", {23'd0, ctrl}, {23'd0, C_BUBBLE});
    #1 chk("lu_stall_clear", {31'd0, stall}, 32'd0);
    tick();
    chk("lu_add_ctrl", {23'd0, ctrl}, {23'd0, C_RTYPE});
    chk("lu_add_rs", {27'd0, ex_rs}, 32'd4);
    chk("lu_add_rt", {27'd0, ex_rt}, 32'd4);
    chk("lu_add_rd", {27'd0, ex_rd}, 32'd5);

    // Flush beats stall: same hazard with a taken branch in MEM
    ifid_ir = 32'h8C240008;
    tick();
    ifid_ir = 32'h00842820; pc_src = 1'b1;
    #1 chk("fl_stall", {31'd0, stall}, 32'd0);
    tick();
    pc_src = 1'b0;
    chk("fl_bubble", {23'd0, ctrl}, {23'd0, C_BUBBLE});

    // Flush of an otherwise normal instruction also bubbles
    ifid_ir = 32'h20060001; pc_src = 1'b1;
    tick();
    pc_src = 1'b0;
    chk("fl_addi_bubble", {23'd0, ctrl}, {23'd0, C_BUBBLE});

    // Register 0 protection, both stored and bypassed
    ifid_ir = 32'h00000000;
    wb_write(5'd0, 32'hFFFFFFFF);
    ifid_ir = 32'h20060001;
    wb_we = 1'b1; wb_reg = 5'd0; wb_data = 32'hFFFFFFFF;
    tick();
    wb_we = 1'b0;
    chk("r0_rs_data", ex_rs_data, 32'd0);
    chk("addi_ctrl", {23'd0, ctrl}, {23'd0, C_ADDI});
    chk("addi_imm", ex_imm, 32'd1);
    ifid_ir = 32'h8C200000;
    tick();
    ifid_ir = 32'h00003820;
    #1 chk("r0_nostall", {31'd0, stall}, 32'd0);
    tick();

    // Unknown opcode reading the load target never stalls, decodes to zero control
    ifid_ir = 32'h8C240008;
    tick();
    ifid_ir = 32'hFC840000;
    #1 chk("unk_nostall", {31'd0, stall}, 32'd0);
    tick();
    chk("unk_ctrl", {23'd0, ctrl}, {23'd0, C_BUBBLE});

    // beq decode
    ifid_ir = 32'h10220003;
    tick();
    chk("beq_ctrl", {23'd0, ctrl}, {23'd0, C_BEQ});

    // sw with negative offset
    ifid_ir = 32'hAC22FFFC; ifid_pc = 32'h40;
    tick();
    chk("sw_imm", ex_imm, 32'hFFFFFFFC);
    chk("sw_ctrl", {23'd0, ctrl}, {23'd0, C_SW});
    chk("sw_rt_data", ex_rt_data, 32'h55);

    // Asynchronous reset mid-run, with a lw in EX and a hazard pending
    ifid_ir = 32'h8C240008;
    tick();
    ifid_ir = 32'h00842820;
    #1 rst = 1'b1;
    #1;
    chk("arst_ctrl", {23'd0, ctrl}, 32'd0);
    chk("arst_pc", ex_pc, 32'd0);
    chk("arst_imm", ex_imm, 32'd0);
    chk("arst_stall", {31'd0, stall}, 32'd0);
    tick();
    rst = 1'b0;
    ifid_ir = 32'h00A04020;
    tick();
    chk("arst_r5", ex_rs_data, 32'd0);
    chk("post_rst_ctrl", {23'd0, ctrl}, {23'd0, C_RTYPE});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the 5-stage pipelined processor, directly downstream of the fetch stage. Each cycle it consumes the IF/ID pair (PC+4, instruction), reads a 32×32 register file, decodes control, and loads the ID/EX pipeline register. It owns load-use hazard detection, driving the stall back to fetch, and squashes the decoded instruction when a branch is taken in MEM. It also hosts the register file written by WB.

## Interface
- No parameters. Register file is 32 × 32 bits; register 0 reads as zero.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- IFID_pc_i  in  32  PC+4 of the instruction in IF/ID.
- IFID_ir_i  in  32  instruction word in IF/ID.
- MEM_ctrl_pc_src_i  in  1  branch taken in MEM this cycle; squash.
- WB_reg_write_i  in  1  register-file write enable.
- WB_write_reg_i  in  5  write address.
- WB_write_data_i  in  32  write data.
- ID_stall_o  out  1  combinational; holds IF/ID.
- IDEX_pc_o  out  32  registered PC+4.
- IDEX_rs_data_o, IDEX_rt_data_o  out  32 each  registered operands.
- IDEX_imm_o  out  32  sign-extended ir[15:0].
- IDEX_rs_o, IDEX_rt_o, IDEX_rd_o  out  5 each  ir[25:21], ir[20:16], ir[15:11].
- IDEX_reg_write_o, IDEX_mem_to_reg_o, IDEX_mem_read_o, IDEX_mem_write_o, IDEX_branch_o, IDEX_alu_src_o, IDEX_reg_dst_o  out  1 each  control.
- IDEX_alu_op_o  out  2  00 add, 01 sub/compare, 10 use funct.

## Operation
- Decode by ir[31:26]:
  - 000000 R-type: reg_write, reg_dst, alu_op=10.
  - 100011 lw: reg_write, mem_to_reg, mem_read, alu_src, alu_op=00.
  - 101011 sw: mem_write, alu_src, alu_op=00.
  - 000100 beq: branch, alu_op=01.
  - 001000 addi: reg_write, alu_src, alu_op=00.
  - Any other opcode, including instruction 0x00000000 decoded as R-type nop, follows the table. Unknown opcodes produce all-zero control.
- Bubble: all seven control bits and alu_op are 0. Data and address fields are don't-care; implement them as loaded normally.
- Register file:
  - Written on the rising edge when WB_reg_write_i=1 and WB_write_reg_i≠0. Writes to register 0 are ignored.
  - Reads are combinational with write-through: if WB writes reg r this cycle and rs or rt is r (r≠0), the operand is WB_write_data_i.
  - Register 0 always reads 0.
- Load-use hazard:
  - Condition: IDEX_mem_read_o=1, IDEX_rt_o≠0, and either IDEX_rt_o=rs, or IDEX_rt_o=rt while the current opcode uses rt as a source (R-type, beq, sw).
  - Unknown opcodes never cause a stall.
- ID_stall_o = hazard AND NOT MEM_ctrl_pc_src_i. A taken branch must never stall, or the fetch of the branch target is lost.
- ID/EX update priority: rst_i > MEM_ctrl_pc_src_i (load bubble) > hazard (load bubble) > normal load of decoded fields.
- Stall is self-clearing: the bubble clears IDEX_mem_read_o, so hazards last exactly one cycle per load.

## Timing
- Reset (asynchronous, immediate):
  - All ID/EX outputs become 0.
  - All 32 registers are cleared to 0.
  - ID_stall_o=0 while in reset, since IDEX_mem_read_o=0.
- Latency: IF/ID contents appear on IDEX_* one rising edge later.
- A WB write in cycle n is visible to a decode in the same cycle n through the bypass.
- ID_stall_o depends only on current IF/ID inputs, IDEX_* state, and MEM_ctrl_pc_src_i. There is no input-to-register path through clk.
- Reset asserted mid-stall or mid-flush overrides everything. On the first edge after release, the block decodes whatever IF/ID presents.

## Test plan
- Reset:
  - Drive rst_i=1 mid-run with IDEX loaded.
  - Required: all IDEX_* = 0 without a clock edge; a subsequent read of r5 returns 0; ID_stall_o=0.
- R-type decode with bypass:
  - Preload r1=7, r2=9.
  - IF/ID ir=0x00221820 (add r3,r1,r2), pc=0x10, WB simultaneously writing r2=0x55.
  - Required next edge: rs_data=7, rt_data=0x55, rd=3, reg_write=1, reg_dst=1, alu_op=10, pc=0x10.
- Load-use stall:
  - Decode lw r4,8(r1) (0x8C240008), then add r5,r4,r4.
  - Required: ID_stall_o=1 for exactly one cycle; the next IDEX is a bubble; the following edge loads the add with rs=rt=4.
- Flush beats stall:
  - Same hazard as the load-use scenario, with MEM_ctrl_pc_src_i=1.
  - Required: ID_stall_o=0 and IDEX is a bubble.
- Register 0 protection:
  - WB writes r0=0xFFFFFFFF.
  - Required: a following decode of rs=0 yields rs_data=0; a lw targeting r0 followed by a use of r0 does not stall.
- Immediate and sw decode:
  - ir=0xAC22FFFC (sw r2,-4(r1)).
  - Required: imm=0xFFFFFFFC, mem_write=1, alu_src=1, reg_write=0.
